countdown_controller: RTL
=========================

Name: countdown_controller

Overview:
- Sequences the countdown-timer datapath of the watch: preset editing, 1 Hz decrementing, pause/resume, and the expiry alarm.
- Consumes single-cycle key pulses already produced by the edge-detect and press-hold logic. Inc pulses may be auto-repeat pulses.
- Drives the h:m:s values to the display mux and an alarm level to the buzzer path.
- Sits between the key-conditioning blocks and the seven-segment display/buzzer.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1, countdown decrement rate. Benches set CLK_HZ=10 for a tick every 10 cycles.
- BLINK_HZ, 2, toggle rate of the edit-field blink output.
- ALARM_SECS, 10, number of ticks the alarm stays active before self-clearing.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- start_stop, input, 1, single-cycle pulse: start, pause or resume.
- edit, input, 1, single-cycle pulse: enter or leave preset edit.
- field_next, input, 1, single-cycle pulse: select the next edit field.
- inc, input, 1, single-cycle pulse: increment the selected field.
- clear, input, 1, single-cycle pulse: abort to IDLE.
- hours, output, 5, displayed hours, 0-23.
- minutes, output, 6, displayed minutes, 0-59.
- seconds, output, 6, displayed seconds, 0-59.
- edit_field, output, 2, selected field: 0=hours, 1=minutes, 2=seconds.
- blink, output, 1, blink phase for the selected field; 1 only in EDIT.
- running, output, 1, 1 only in RUN.
- alarm, output, 1, 1 only in ALARM.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; preset=00:00:00; count=00:00:00.
  - edit_field=0; blink=0; running=0; alarm=0.
  - Tick prescaler, blink prescaler and alarm counter all cleared.
  - Reset asserted mid-RUN or mid-ALARM takes effect immediately.
- Timing:
  - All outputs are registered.
  - A pulse sampled at edge k is reflected in the outputs after edge k.
- Displayed value: IDLE and EDIT show the preset; RUN, PAUSE and ALARM show count.
- Tick: prescaler counts 0..CLK_HZ/TICK_HZ-1 and tick=1 on the terminal cycle.
  - Counts only in RUN and ALARM.
  - Holds its value in PAUSE, so a resume continues the partial second.
  - Clears to 0 when entering RUN from IDLE.
- Same-cycle priority among pulses: clear > start_stop > edit > field_next > inc. Lower-priority pulses in that cycle are ignored.
- IDLE:
  - start_stop with preset non-zero -> RUN, count<=preset.
  - start_stop with preset 00:00:00 -> ignored, stay IDLE.
  - edit -> EDIT, edit_field<=0.
- EDIT:
  - inc increments the selected preset field with wrap: hours 23->0, minutes 59->0, seconds 59->0. No carry between fields.
  - field_next advances 0->1->2->0.
  - edit or clear -> IDLE with the preset retained.
  - start_stop ignored.
  - blink toggles every CLK_HZ/(2*BLINK_HZ) cycles; blink=0 on exit.
- RUN:
  - On tick, count decrements with borrow: ss 0->59 borrows mm; mm 0->59 borrows hh.
  - If the decrement results in 00:00:00 -> ALARM, with alarm counter=0.
  - start_stop -> PAUSE. If tick coincides, the decrement is applied first.
  - clear -> IDLE; count discarded.
- PAUSE:
  - start_stop -> RUN with count unchanged.
  - clear -> IDLE.
  - edit, field_next and inc ignored.
- ALARM:
  - count holds at 00:00:00; alarm=1.
  - Each tick increments the alarm counter; after ALARM_SECS ticks -> IDLE.
  - Any of clear, start_stop or edit -> IDLE immediately; that pulse has no other effect.
- Preset is never modified outside EDIT. Returning to IDLE always shows the last preset.

Test Plan:
- Reset with reset_n low mid-cycle -> all outputs 0 asynchronously; hours/minutes/seconds=0; state IDLE.
- edit, then 3 inc, then field_next, then 61 inc, then edit -> preset=03:01:00; edit_field sequence 0,1; blink toggling only while in EDIT.
- CLK_HZ=10, preset 00:01:01, start_stop -> running=1; after 10 cycles 00:01:00; after 20 cycles 00:00:59 (borrow correct).
- CLK_HZ=10, RUN at 00:00:05, start_stop at prescaler=4, wait 50 cycles, start_stop -> still 00:00:05 during pause; next decrement 6 cycles after resume.
- CLK_HZ=10, preset 00:00:02, ALARM_SECS=3, start -> alarm=1 at cycle 20; alarm=0 and state IDLE at cycle 50; display shows 00:00:02.
- clear and start_stop in the same cycle during RUN -> IDLE, running=0; start_stop in IDLE with preset 00:00:00 -> stays IDLE.

Source files
------------

// File: rtl/countdown_controller.sv
// Countdown-timer sequencer: preset editing, 1 Hz decrement with borrow,
// pause/resume and a self-clearing expiry alarm. All outputs are registered.
module countdown_controller #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int BLINK_HZ   = 2,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       edit,
  input  logic       field_next,
  input  logic       inc,
  input  logic       clear,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic       running,
  output logic       alarm
);

  typedef struct packed {
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
  } hms_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT,
    S_RUN,
    S_PAUSE,
    S_ALARM
  } state_t;

  localparam int TICK_DIV  = (CLK_HZ / TICK_HZ) > 0 ? (CLK_HZ / TICK_HZ) : 1;
  localparam int BLINK_DIV = (CLK_HZ / (2 * BLINK_HZ)) > 0 ? (CLK_HZ / (2 * BLINK_HZ)) : 1;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam int AW = ALARM_SECS > 1 ? $clog2(ALARM_SECS + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

  state_t          state;
  hms_t            preset;
  hms_t            count;
  hms_t            disp;
  hms_t            count_dec;
  hms_t            preset_inc;
  logic [PW-1:0]   presc;
  logic [BW-1:0]   blink_cnt;
  logic [AW-1:0]   alarm_cnt;
  logic            tick;

  assign hours   = disp.hh;
  assign minutes = disp.mm;
  assign seconds = disp.ss;

  // The prescaler only advances while the countdown or alarm is live.
  assign tick = ((state == S_RUN) || (state == S_ALARM)) && (presc == PRE_LAST);

  always_comb begin
    count_dec = count;
    if (count.ss != 6'd0) begin
      count_dec.ss = count.ss - 6'd1;
    end else begin
      count_dec.ss = 6'd59;
      if (count.mm != 6'd0) begin
        count_dec.mm = count.mm - 6'd1;
      end else begin
        count_dec.mm = 6'd59;
        count_dec.hh = count.hh - 5'd1;
      end
    end
  end

  // Fields wrap independently; editing never carries into a neighbour.
  always_comb begin
    preset_inc = preset;
    case (edit_field)
      2'd0:    preset_inc.hh = (preset.hh == 5'd23) ? 5'd0 : preset.hh + 5'd1;
      2'd1:    preset_inc.mm = (preset.mm == 6'd59) ? 6'd0 : preset.mm + 6'd1;
      2'd2:    preset_inc.ss = (preset.ss == 6'd59) ? 6'd0 : preset.ss + 6'd1;
      default: preset_inc = preset;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      preset     <= '0;
      count      <= '0;
      disp       <= '0;
      presc      <= '0;
      blink_cnt  <= '0;
      alarm_cnt  <= '0;
      edit_field <= 2'd0;
      blink      <= 1'b0;
      running    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      if (state == S_EDIT) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (!clear && start_stop) begin
            if (preset != '0) begin
              state   <= S_RUN;
              count   <= preset;
              disp    <= preset;
              presc   <= '0;
              running <= 1'b1;
            end
          end else if (!clear && edit) begin
            state      <= S_EDIT;
            edit_field <= 2'd0;
            blink_cnt  <= '0;
            blink      <= 1'b0;
          end
        end

        S_EDIT: begin
          if (clear || (!start_stop && edit)) begin
            state     <= S_IDLE;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end else if (!start_stop && field_next) begin
            edit_field <= (edit_field == 2'd2) ? 2'd0 : edit_field + 2'd1;
          end else if (!start_stop && inc) begin
            preset <= preset_inc;
            disp   <= preset_inc;
          end
        end

        S_RUN: begin
          if (clear) begin
            state   <= S_IDLE;
            disp    <= preset;
            running <= 1'b0;
          end else begin
            // A pause in the same cycle as a tick keeps the completed second.
            if (tick) begin
              count <= count_dec;
              disp  <= count_dec;
              presc <= '0;
            end else if (!start_stop) begin
              presc <= presc + PW'(1);
            end
            if (tick && (count_dec == '0)) begin
              state     <= S_ALARM;
              alarm_cnt <= '0;
              alarm     <= 1'b1;
              running   <= 1'b0;
            end else if (start_stop) begin
              state   <= S_PAUSE;
              running <= 1'b0;
            end
          end
        end

        S_PAUSE: begin
          if (clear) begin
            state <= S_IDLE;
            disp  <= preset;
          end else if (start_stop) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end

        S_ALARM: begin
          if (clear || start_stop || edit) begin
            state <= S_IDLE;
            disp  <= preset;
            alarm <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            if (alarm_cnt == ALARM_LAST) begin
              state <= S_IDLE;
              disp  <= preset;
              alarm <= 1'b0;
            end else begin
              alarm_cnt <= alarm_cnt + AW'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end

        default: begin
          state   <= S_IDLE;
          disp    <= preset;
          running <= 1'b0;
          alarm   <= 1'b0;
          blink   <= 1'b0;
        end
      endcase
    end
  end

endmodule
